axi4_lite_regfile_slave: RTL and testbench

Parametrised AXI4-Lite slave register file, next generation of the team's fixed 32x32 slave. Adds configurable data width and register count, WSTRB byte-lane writes, independent concurrent read and write paths, AW/W acceptance in either order, and decode-error responses. Sits behind the AXI4-Lite interconnect as the control/status register bank of a peripheral.

---
 rtl/axi4_lite_pkg.sv | 36 +++
 rtl/axi4_lite_reg_bank.sv | 51 +++++
 rtl/axi4_lite_regfile_slave.sv | 227 ++++++++++++++++++++++
 tb/tb_axi4_lite_regfile_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register file slave: response codes, FSM states, byte merge.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package axi4_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WAIT_W  = 2'd1,
    WR_WAIT_AW = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  // Byte-lane merge sized for the widest legal bus (64 bits / 8 lanes);
  // narrower callers zero-extend the inputs and truncate the result.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// NUM_REGS x DATA_WIDTH register storage with one strobed write port and one read port.
// Latency: write lands on the clock edge with wr_en high; read is combinational from the flops.
// Backpressure: none; the port is always ready, the caller owns flow control.
// Ports: clk/rst_n (async active-low, loads RESET_VALUE), wr_en/wr_idx/wr_data/wr_strb,
//        rd_idx -> rd_data (returns 0 for an index beyond NUM_REGS).
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int IDX_W      = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && ({1'b0, wr_idx} < NUM_REGS_L)) begin
      regs_d[wr_idx] = DATA_WIDTH'(byte_merge(64'(regs_q[wr_idx]), 64'(wr_data), 8'(wr_strb)));
    end
  end

  // Reads the current flops, so a read and write to the same index on one
  // edge sees the pre-write contents.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < NUM_REGS_L) rd_data = regs_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave register file with WSTRB writes, independent read/write FSMs and decode errors.
// Latency: BVALID one cycle after the later AW/W handshake; RVALID one cycle after AR handshake.
// Backpressure: BREADY/RREADY may stall indefinitely; responses are held stable, no new accepts.
// Ports: ACLK, ARESETN (async active-low); AW/W/B write channels; AR/R read channels.
// Build option: define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR
// instead of OKAY (the access is dropped / reads 0 either way).
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam axi_resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam axi_resp_t OOR_RESP = RESP_OKAY;
`endif

  // Out of range when the index field points past the last register or any
  // address bit above the index field is set.
  function automatic logic addr_oor(input logic [ADDRESS-1:0] addr);
    return ({1'b0, addr[ADDR_LSB +: IDX_W]} >= NUM_REGS_L) ||
           ((addr >> (ADDR_LSB + IDX_W)) != '0);
  endfunction

  // ---------------- write path ----------------
  wr_state_t             wr_state_q, wr_state_d;
  logic [ADDRESS-1:0]    aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  axi_resp_t             bresp_q, bresp_d;

  logic                  aw_hs, w_hs, commit, cm_oor, wr_en;
  logic [ADDRESS-1:0]    cm_addr;
  logic [DATA_WIDTH-1:0] cm_data;
  logic [STRB_W-1:0]     cm_strb;

  always_comb begin
    aw_hs      = S_AWVALID && awready_q;
    w_hs       = S_WVALID && wready_q;
    wr_state_d = wr_state_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    // Commit operands come from the live bus or from whichever half was
    // captured earlier, depending on arrival order.
    cm_addr    = S_AWADDR;
    cm_data    = S_WDATA;
    cm_strb    = S_WSTRB;

    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end else if (aw_hs) begin
          aw_addr_d  = S_AWADDR;
          wr_state_d = WR_WAIT_W;
        end else if (w_hs) begin
          w_data_d   = S_WDATA;
          w_strb_d   = S_WSTRB;
          wr_state_d = WR_WAIT_AW;
        end
      end
      WR_WAIT_W: begin
        cm_addr = aw_addr_q;
        if (w_hs) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_WAIT_AW: begin
        cm_data = w_data_q;
        cm_strb = w_strb_q;
        if (aw_hs) begin
          commit     = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid_q && S_BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase

    cm_oor = addr_oor(cm_addr);
    wr_en  = commit && !cm_oor;
    if (commit) bresp_d = cm_oor ? OOR_RESP : RESP_OKAY;

    // Outputs are decoded from the next state so they are pure flops; after
    // reset the idle readies come up on the first clock edge.
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_AW);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_W);
    bvalid_d  = (wr_state_d == WR_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read path ----------------
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  axi_resp_t             rresp_q, rresp_d;
  logic                  ar_hs, ar_oor;
  logic [DATA_WIDTH-1:0] bank_rd_data;

  always_comb begin
    ar_hs      = S_ARVALID && arready_q;
    ar_oor     = addr_oor(S_ARADDR);
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d    = ar_oor ? '0 : bank_rd_data;
          rresp_d    = ar_oor ? OOR_RESP : RESP_OKAY;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid_q && S_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase

    arready_d = (rd_state_d == RD_IDLE);
    rvalid_d  = (rd_state_d == RD_DATA);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .RESET_VALUE (RESET_VALUE)
  ) u_bank (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (wr_en),
    .wr_idx  (cm_addr[ADDR_LSB +: IDX_W]),
    .wr_data (cm_data),
    .wr_strb (cm_strb),
    .rd_idx  (S_ARADDR[ADDR_LSB +: IDX_W]),
    .rd_data (bank_rd_data)
  );

  assign S_AWREADY = awready_q;
  assign S_WREADY  = wready_q;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_ARREADY = arready_q;
  assign S_RVALID  = rvalid_q;
  assign S_RDATA   = rdata_q;
  assign S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave: handshakes, strobes, stalls, decode errors, reset.
// Latency: n/a.
// Backpressure: exercised on B and R channels.
module tb_axi4_lite_regfile_slave;

  localparam logic [31:0] RV = 32'h1234_5678;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [31:0] S_ARADDR = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 ACLK = ~ACLK;

  axi4_lite_regfile_slave #(
    .ADDRESS     (32),
    .DATA_WIDTH  (32),
    .NUM_REGS    (32),
    .RESET_VALUE (RV)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .S_AWADDR  (S_AWADDR),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARADDR  (S_ARADDR),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    logic aw_done, w_done, a_rdy, w_rdy;
    aw_done = 1'b0;
    w_done  = 1'b0;
    S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      a_rdy = S_AWREADY;
      w_rdy = S_WREADY;
      tick();
      if (a_rdy && S_AWVALID) begin aw_done = 1'b1; S_AWVALID = 1'b0; end
      if (w_rdy && S_WVALID)  begin w_done  = 1'b1; S_WVALID  = 1'b0; end
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    chk({tag, "_hs"}, {62'd0, aw_done, w_done}, 64'd3);
    chk({tag, "_bvalid"}, S_BVALID, 1);
    chk({tag, "_bresp"}, S_BRESP, exp_resp);
    S_BREADY = 1'b1;
    tick();
    S_BREADY = 1'b0;
    chk({tag, "_bdone"}, S_BVALID, 0);
    chk({tag, "_awrdy_back"}, {S_AWREADY, S_WREADY}, 2'b11);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic done, r_rdy;
    done = 1'b0;
    S_ARADDR = addr;
    S_ARVALID = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      r_rdy = S_ARREADY;
      tick();
      if (r_rdy) done = 1'b1;
    end
    S_ARVALID = 1'b0;
    chk({tag, "_hs"}, done, 1);
    chk({tag, "_rvalid"}, S_RVALID, 1);
    chk({tag, "_rdata"}, S_RDATA, exp_data);
    chk({tag, "_rresp"}, S_RRESP, exp_resp);
    S_RREADY = 1'b1;
    tick();
    S_RREADY = 1'b0;
    chk({tag, "_rdone"}, {S_RVALID, S_ARREADY}, 2'b01);
  endtask

  initial begin
    // Reset state and ready bring-up.
    #3;
    chk("rst_rdy", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
    chk("rst_vld", {S_BVALID, S_RVALID}, 2'b00);
    chk("rst_resp", {S_BRESP, S_RRESP}, 4'h0);
    chk("rst_rdata", S_RDATA, 0);
    tick(); tick();
    ARESETN = 1'b1;
    chk("rel_rdy_lo", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
    tick();
    chk("rel_rdy_hi", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

    // Simultaneous AW/W, then read back.
    do_write("wr08", 32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);
    do_read("rd08", 32'h08, 32'hDEAD_BEEF, 2'b00);

    // WSTRB=0 is a no-op answered OKAY.
    do_write("wr08_s0", 32'h08, 32'h0000_0000, 4'h0, 2'b00);
    do_read("rd08_s0", 32'h08, 32'hDEAD_BEEF, 2'b00);

    // W before AW with a single byte lane.
    S_WDATA = 32'h0000_00AA; S_WSTRB = 4'h1; S_WVALID = 1'b1;
    tick();
    S_WVALID = 1'b0;
    chk("wfirst_rdy", {S_AWREADY, S_WREADY}, 2'b10);
    tick(); tick();
    chk("wfirst_wait", {S_AWREADY, S_WREADY, S_BVALID}, 3'b100);
    S_AWADDR = 32'h04; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    chk("wfirst_bvalid", S_BVALID, 1);
    chk("wfirst_bresp", S_BRESP, 2'b00);
    S_BREADY = 1'b1; tick(); S_BREADY = 1'b0;
    do_read("rd04", 32'h04, 32'h1234_56AA, 2'b00);

    // B stalled for 5 cycles while a read of 0x00 completes (itself stalled one cycle).
    S_AWADDR = 32'h0C; S_WDATA = 32'h0000_0055; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    chk("stall_bvalid0", S_BVALID, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin S_ARADDR = 32'h00; S_ARVALID = 1'b1; end
      if (i == 2) S_RREADY = 1'b1;
      tick();
      S_ARVALID = 1'b0; S_RREADY = 1'b0;
      chk("stall_b", {S_BVALID, S_BRESP}, 3'b100);
      if (i < 2) chk("stall_r", {S_RVALID, S_RRESP, S_RDATA}, {1'b1, 2'b00, RV});
      if (i == 2) chk("stall_rdone", S_RVALID, 0);
    end
    S_BREADY = 1'b1; tick(); S_BREADY = 1'b0;
    chk("stall_bdone", S_BVALID, 0);
    do_read("rd0c", 32'h0C, 32'h0000_0055, 2'b00);

    // Middle byte lanes only.
    do_write("wr0c_s6", 32'h0C, 32'hAABB_CCDD, 4'b0110, 2'b00);
    do_read("rd0c_s6", 32'h0C, 32'h00BB_CC55, 2'b00);

    // Out-of-range: index NUM_REGS (aliases reg0 if decode were wrong) and high address bit.
    do_write("wr_oor", 32'h80, 32'hFFFF_FFFF, 4'hF, EXP_OOR);
    do_read("rd00_keep", 32'h00, RV, 2'b00);
    do_read("rd_oor", 32'h80, 32'h0, EXP_OOR);
    do_read("rd_oor_hi", 32'h1000_0008, 32'h0, EXP_OOR);

    // Read and write commit to the same register on one edge.
    do_write("wr10", 32'h10, 32'h1, 4'hF, 2'b00);
    S_AWADDR = 32'h10; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    chk("col_wait_w", {S_AWREADY, S_WREADY}, 2'b01);
    S_WDATA = 32'h2; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    S_ARADDR = 32'h10; S_ARVALID = 1'b1;
    tick();
    S_WVALID = 1'b0; S_ARVALID = 1'b0;
    chk("col_vld", {S_RVALID, S_BVALID}, 2'b11);
    chk("col_rdata", S_RDATA, 32'h1);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    tick();
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    do_read("col_after", 32'h10, 32'h2, 2'b00);

    // Reset while in WR_WAIT_W and RD_DATA.
    S_AWADDR = 32'h14; S_AWVALID = 1'b1;
    tick();
    S_AWVALID = 1'b0;
    S_ARADDR = 32'h08; S_ARVALID = 1'b1;
    tick();
    S_ARVALID = 1'b0;
    chk("pre_rst", {S_AWREADY, S_WREADY, S_RVALID}, 3'b011);
    ARESETN = 1'b0;
    #2;
    chk("mid_rst_rdy", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
    chk("mid_rst_vld", {S_BVALID, S_RVALID}, 2'b00);
    chk("mid_rst_data", {S_RDATA, S_RRESP, S_BRESP}, 36'h0);
    tick(); tick();
    ARESETN = 1'b1;
    chk("mid_rel_lo", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
    tick();
    chk("mid_rel_hi", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
    do_read("rst_r08", 32'h08, RV, 2'b00);
    do_read("rst_r10", 32'h10, RV, 2'b00);
    do_write("rst_w14", 32'h14, 32'hCAFE_0000, 4'b1100, 2'b00);
    do_read("rst_r14", 32'h14, 32'hCAFE_5678, 2'b00);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
